gcd_engine: RTL and testbench
=============================

GCD_ENGINE -- requirements
Module: gcd_engine

Interface
REQ-001 Parameter WIDTH, default 16: operand/result width in bits, legal range 2..64.
REQ-002 Parameter CW, default $clog2(4*WIDTH+2): out_cycles width.
REQ-003 clk  input  1  clock; all state updates on posedge.
REQ-004 nrst  input  1  reset, asynchronous, active-low.
REQ-005 clear  input  1  synchronous abort; returns block to IDLE.
REQ-006 in_valid  input  1  operand pair offered.
REQ-007 in_ready  output  1  block can accept operands.
REQ-008 in_a, in_b  input  WIDTH each  unsigned operands.
REQ-009 out_valid  output  1  result available.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 out_gcd  output  WIDTH  gcd(in_a, in_b).
REQ-012 out_cycles  output  CW  CALC cycles spent on this result.
REQ-013 busy  output  1  high when state is not IDLE.

Function
REQ-014 FSM SHALL have states IDLE, CALC, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-015 Accept: in_valid && in_ready at posedge latches in_a/in_b into a/b, clears shift count k and cycle count cnt.
REQ-016 Zero operand: on accept, if in_a==0 or in_b==0, go straight to DONE with out_gcd = in_a|in_b, out_cycles = 0 (gcd(0,0)=0).
REQ-017 Otherwise go to CALC; per CALC cycle exactly one step (Stein binary GCD), cnt += 1:
- a==b: out_gcd <= a << k, out_cycles <= cnt+1, go DONE;
- a,b both even: a>>=1, b>>=1, k+=1;
- only a even: a>>=1; only b even: b>>=1;
- both odd, a>b: a<=a-b; both odd, b>a: b<=b-a.
REQ-018 Arithmetic SHALL be unsigned, WIDTH bits; subtraction never underflows; a<<k never overflows WIDTH (k ≤ trailing zeros of both operands).
REQ-019 CALC SHALL terminate within 4*WIDTH cycles; cnt SHALL never wrap.
REQ-020 DONE: out_gcd/out_cycles stable while out_valid && !out_ready; on out_ready go IDLE next cycle.
REQ-021 in_valid in any state other than IDLE SHALL be ignored (no queuing).
REQ-022 clear high (any state) SHALL force IDLE next cycle, discarding in-flight work; clear has priority over accept and out_ready; out_gcd/out_cycles retain previous values.
REQ-023 Minimum accept-to-out_valid latency: 1 cycle (zero operand); equal nonzero operands: 2 cycles, out_cycles = 1.

Reset
REQ-024 nrst low SHALL asynchronously force state IDLE, a=b=0, k=0, cnt=0, out_gcd=0, out_cycles=0.
REQ-025 Reset outputs: in_ready=1, out_valid=0, busy=0.
REQ-026 Reset mid-CALC or mid-DONE SHALL abandon the operation; no out_valid after release until a new accept.

Structure
REQ-027 Shared package gcd_pkg SHALL hold the state typedef (IDLE, CALC, DONE) and the default WIDTH constant.
REQ-028 One sub-module gcd_step (combinational, parameterised WIDTH): takes a, b, k, returns next a, b, k and an eq flag; gcd_engine holds FSM, registers, handshake.

Verification
REQ-029 WIDTH=16, (48,18) accepted, out_ready=1 -> out_gcd=6, one out_valid pulse, in_ready high the cycle after.
REQ-030 (0,0) -> out_gcd=0, out_cycles=0 one cycle after accept; (0,35) -> 35; (35,0) -> 35.
REQ-031 (65535,65535) -> out_gcd=65535, out_cycles=1; (32768,16384) -> 16384; (65521,65519) -> 1 within 64 CALC cycles.
REQ-032 (48,18) with out_ready low 10 cycles -> out_valid/out_gcd=6/out_cycles stable all 10 cycles; in_valid with (7,14) during them ignored.
REQ-033 nrst pulsed mid-CALC of (1000,250) -> reset values immediately; next accept (12,8) -> 4; clear mid-CALC -> IDLE next cycle, no out_valid.
REQ-034 Random 1000 pairs, WIDTH in {8,16,32} -> out_gcd matches reference model; out_cycles ≤ 4*WIDTH.

Source files
------------

// File: rtl/gcd_pkg.sv
// Shared definitions for the binary GCD engine: FSM state type and default operand width.
package gcd_pkg;

  localparam int unsigned GCD_WIDTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } gcd_state_e;

endpackage : gcd_pkg

// File: rtl/gcd_step.sv
// One combinational Stein binary-GCD step.
// Ports:
//   a_i, b_i  current operands (WIDTH)
//   k_i       common power-of-two count factored out so far (KW)
//   a_o, b_o  operands after this step
//   k_o       updated power-of-two count
//   eq_o      operands equal: the odd part of the gcd is a_i
module gcd_step
  import gcd_pkg::*;
#(
  parameter int unsigned WIDTH = GCD_WIDTH_DEFAULT,
  parameter int unsigned KW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [KW-1:0]    k_i,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  output logic [KW-1:0]    k_o,
  output logic             eq_o
);

  logic eq;

  assign eq   = (a_i == b_i);
  assign eq_o = eq;

  // Exactly one reduction per call; the odd-odd subtraction always takes larger minus smaller.
  always_comb begin
    a_o = a_i;
    b_o = b_i;
    k_o = k_i;
    if (!eq) begin
      if (!a_i[0] && !b_i[0]) begin
        a_o = a_i >> 1;
        b_o = b_i >> 1;
        k_o = KW'(k_i + KW'(1));
      end else if (!a_i[0]) begin
        a_o = a_i >> 1;
      end else if (!b_i[0]) begin
        b_o = b_i >> 1;
      end else if (a_i > b_i) begin
        a_o = a_i - b_i;
      end else begin
        b_o = b_i - a_i;
      end
    end
  end

endmodule : gcd_step

// File: rtl/gcd_engine.sv
// Iterative unsigned GCD engine with valid/ready handshakes on both sides.
// Ports:
//   clk, nrst            clock, asynchronous active-low reset
//   clear                synchronous abort back to IDLE
//   in_valid/in_ready    operand handshake; in_a, in_b operands (WIDTH)
//   out_valid/out_ready  result handshake; out_gcd (WIDTH), out_cycles (CW)
//   busy                 engine not idle
module gcd_engine
  import gcd_pkg::*;
#(
  parameter int unsigned WIDTH = GCD_WIDTH_DEFAULT,
  parameter int unsigned CW    = $clog2(4 * WIDTH + 2)
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_gcd,
  output logic [CW-1:0]    out_cycles,
  output logic             busy
);

  localparam int unsigned KW = $clog2(WIDTH + 1);

  gcd_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [KW-1:0]    k_q, k_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] gcd_q, gcd_d;
  logic [CW-1:0]    cyc_q, cyc_d;
  logic             in_ready_q, out_valid_q, busy_q;

  logic [WIDTH-1:0] step_a, step_b;
  logic [KW-1:0]    step_k;
  logic             step_eq;

  gcd_step #(
    .WIDTH (WIDTH),
    .KW    (KW)
  ) u_step (
    .a_i  (a_q),
    .b_i  (b_q),
    .k_i  (k_q),
    .a_o  (step_a),
    .b_o  (step_b),
    .k_o  (step_k),
    .eq_o (step_eq)
  );

  // Next-state and datapath update; clear overrides everything and keeps the last result.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    gcd_d   = gcd_q;
    cyc_d   = cyc_q;

    if (clear) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_d   = in_a;
            b_d   = in_b;
            k_d   = '0;
            cnt_d = '0;
            if (in_a == '0 || in_b == '0) begin
              gcd_d   = in_a | in_b;
              cyc_d   = '0;
              state_d = DONE;
            end else begin
              state_d = CALC;
            end
          end
        end
        CALC: begin
          cnt_d = CW'(cnt_q + CW'(1));
          if (step_eq) begin
            // k never exceeds the common trailing zeros, so the shift cannot overflow.
            gcd_d   = a_q << k_q;
            cyc_d   = CW'(cnt_q + CW'(1));
            state_d = DONE;
          end else begin
            a_d = step_a;
            b_d = step_b;
            k_d = step_k;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State, datapath and handshake flags; flags are registered from the next state.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      k_q         <= '0;
      cnt_q       <= '0;
      gcd_q       <= '0;
      cyc_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      k_q         <= k_d;
      cnt_q       <= cnt_d;
      gcd_q       <= gcd_d;
      cyc_q       <= cyc_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
      busy_q      <= (state_d != IDLE);
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign busy       = busy_q;
  assign out_gcd    = gcd_q;
  assign out_cycles = cyc_q;

endmodule : gcd_engine

// File: tb/tb_gcd_engine.sv
// Self-checking bench for gcd_engine: directed vectors and corner sequences on a 16-bit
// instance, plus random pairs driven into 8/16/32-bit instances against a Euclid model.
module tb_gcd_engine;

  localparam int unsigned CW8  = $clog2(4 * 8 + 2);
  localparam int unsigned CW16 = $clog2(4 * 16 + 2);
  localparam int unsigned CW32 = $clog2(4 * 32 + 2);

  logic clk = 1'b0;
  logic nrst;
  logic clear;
  logic out_ready;

  logic            iv8, ir8, ov8, busy8;
  logic [7:0]      a8, b8, g8;
  logic [CW8-1:0]  cyc8;
  logic            iv16, ir16, ov16, busy16;
  logic [15:0]     a16, b16, g16;
  logic [CW16-1:0] cyc16;
  logic            iv32, ir32, ov32, busy32;
  logic [31:0]     a32, b32, g32;
  logic [CW32-1:0] cyc32;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  gcd_engine #(.WIDTH(8)) u8 (
    .clk(clk), .nrst(nrst), .clear(clear), .in_valid(iv8), .in_ready(ir8),
    .in_a(a8), .in_b(b8), .out_valid(ov8), .out_ready(out_ready),
    .out_gcd(g8), .out_cycles(cyc8), .busy(busy8));

  gcd_engine #(.WIDTH(16)) u16 (
    .clk(clk), .nrst(nrst), .clear(clear), .in_valid(iv16), .in_ready(ir16),
    .in_a(a16), .in_b(b16), .out_valid(ov16), .out_ready(out_ready),
    .out_gcd(g16), .out_cycles(cyc16), .busy(busy16));

  gcd_engine #(.WIDTH(32)) u32 (
    .clk(clk), .nrst(nrst), .clear(clear), .in_valid(iv32), .in_ready(ir32),
    .in_a(a32), .in_b(b32), .out_valid(ov32), .out_ready(out_ready),
    .out_gcd(g32), .out_cycles(cyc32), .busy(busy32));

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] g;
    int          cyc;    // exact out_cycles, or upper bound when exact is 0
    bit          exact;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_le(input string name, input longint unsigned act, input longint unsigned lim);
    n_checks++;
    if (act > lim) begin
      n_fail++;
      $display("FAIL %s: got %0d expected <= %0d", name, act, lim);
    end
  endtask

  // Reference gcd by Euclid's remainder algorithm.
  function automatic longint unsigned ref_gcd(input longint unsigned x, input longint unsigned y);
    longint unsigned t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  function automatic longint unsigned rnd_op(input int w);
    longint unsigned m;
    longint unsigned r;
    m = (64'd1 << w) - 64'd1;
    r = {$urandom(), $urandom()};
    case ($urandom_range(0, 7))
      0:       return 64'd0;
      1:       return (r & m) >> $urandom_range(0, w - 1);
      default: return r & m;
    endcase
  endfunction

  task automatic make_pair(input int w, output longint unsigned a, output longint unsigned b);
    longint unsigned m;
    int s;
    m = (64'd1 << w) - 64'd1;
    a = rnd_op(w);
    b = rnd_op(w);
    case ($urandom_range(0, 3))
      0: b = a;
      1: begin
        s = $urandom_range(0, w / 2);
        a = (a << s) & m;
        b = (b << s) & m;
      end
      default: ;
    endcase
  endtask

  // Cycles from accept edge until out_valid is seen on the 16-bit instance.
  task automatic wait_valid16(input int bound, output int lat);
    lat = 1;
    while (!ov16 && lat < bound) begin
      tick();
      lat++;
    end
    if (!ov16) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_valid16: no out_valid within %0d cycles", bound);
    end
  endtask

  task automatic accept16(input logic [15:0] a, input logic [15:0] b);
    iv16 = 1'b1;
    a16  = a;
    b16  = b;
    tick();
    iv16 = 1'b0;
  endtask

  vec_t vecs[9];

  initial begin
    int lat;
    bit any_ov;
    longint unsigned ra8, rb8, ra16, rb16, ra32, rb32;
    bit [2:0] seen;
    longint unsigned rg8, rg16, rg32, rc8, rc16, rc32;

    vecs[0] = '{16'd48,    16'd18,    16'd6,     7,  1'b1};
    vecs[1] = '{16'd0,     16'd0,     16'd0,     0,  1'b1};
    vecs[2] = '{16'd0,     16'd35,    16'd35,    0,  1'b1};
    vecs[3] = '{16'd35,    16'd0,     16'd35,    0,  1'b1};
    vecs[4] = '{16'd65535, 16'd65535, 16'd65535, 1,  1'b1};
    vecs[5] = '{16'd32768, 16'd16384, 16'd16384, 16, 1'b1};
    vecs[6] = '{16'd65521, 16'd65519, 16'd1,     64, 1'b0};
    vecs[7] = '{16'd12,    16'd8,     16'd4,     6,  1'b1};
    vecs[8] = '{16'd7,     16'd14,    16'd7,     2,  1'b1};

    nrst = 1'b0; clear = 1'b0; out_ready = 1'b1;
    iv8 = 1'b0; iv16 = 1'b0; iv32 = 1'b0;
    a8 = '0; b8 = '0; a16 = '0; b16 = '0; a32 = '0; b32 = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",   ir16,  1);
    check("rst_out_valid",  ov16,  0);
    check("rst_busy",       busy16, 0);
    check("rst_out_gcd",    g16,   0);
    check("rst_out_cycles", cyc16, 0);
    @(negedge clk);
    nrst = 1'b1;
    tick();

    // Directed vectors with the consumer always ready.
    foreach (vecs[i]) begin
      accept16(vecs[i].a, vecs[i].b);
      check("vec_busy_after_accept", busy16, 1);
      wait_valid16(100, lat);
      check("vec_gcd", g16, vecs[i].g);
      if (vecs[i].exact) begin
        check("vec_cycles", cyc16, longint'(vecs[i].cyc));
        check("vec_latency", longint'(lat), longint'(vecs[i].cyc + 1));
      end else begin
        check_le("vec_cycles_bound", cyc16, longint'(vecs[i].cyc));
      end
      tick();
      check("vec_single_pulse", ov16, 0);
      check("vec_in_ready_after", ir16, 1);
    end

    // Consumer stalls for 10 cycles while new operands are offered.
    out_ready = 1'b0;
    accept16(16'd48, 16'd18);
    wait_valid16(100, lat);
    for (int i = 0; i < 10; i++) begin
      check("hold_valid",  ov16,  1);
      check("hold_gcd",    g16,   6);
      check("hold_cycles", cyc16, 7);
      iv16 = 1'b1; a16 = 16'd7; b16 = 16'd14;
      tick();
    end
    iv16 = 1'b0;
    out_ready = 1'b1;
    tick();
    check("hold_release_valid", ov16, 0);
    check("hold_release_ready", ir16, 1);
    check("hold_gcd_retained",  g16,  6);
    tick();
    check("hold_no_queued_op", ov16, 0);
    check("hold_idle", busy16, 0);

    // Asynchronous reset in the middle of CALC.
    accept16(16'd1000, 16'd250);
    tick();
    check("rst_mid_busy", busy16, 1);
    #2 nrst = 1'b0;
    #1;
    check("rst_mid_in_ready",   ir16,  1);
    check("rst_mid_out_valid",  ov16,  0);
    check("rst_mid_busy_low",   busy16, 0);
    check("rst_mid_out_gcd",    g16,   0);
    check("rst_mid_out_cycles", cyc16, 0);
    @(negedge clk);
    nrst = 1'b1;
    any_ov = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      any_ov = any_ov | ov16;
    end
    check("rst_no_stale_valid", any_ov, 0);
    accept16(16'd12, 16'd8);
    wait_valid16(100, lat);
    check("post_rst_gcd", g16, 4);
    tick();

    // Clear mid-CALC abandons the job and keeps the previous result.
    accept16(16'd65521, 16'd65519);
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_in_ready",   ir16,  1);
    check("clear_busy",       busy16, 0);
    check("clear_gcd_kept",   g16,   4);
    check("clear_cycles_kept", cyc16, 6);
    any_ov = 1'b0;
    for (int i = 0; i < 80; i++) begin
      any_ov = any_ov | ov16;
      tick();
    end
    check("clear_no_valid", any_ov, 0);

    // Clear wins over a simultaneous accept.
    iv16 = 1'b1; a16 = 16'd5; b16 = 16'd5; clear = 1'b1;
    tick();
    iv16 = 1'b0; clear = 1'b0;
    check("clear_prio_ready", ir16, 1);
    tick();
    check("clear_prio_no_valid", ov16, 0);

    // Random pairs into all three widths at once.
    for (int n = 0; n < 1000; n++) begin
      make_pair(8,  ra8,  rb8);
      make_pair(16, ra16, rb16);
      make_pair(32, ra32, rb32);
      check("rnd_all_idle", {ir8, ir16, ir32, busy8, busy16, busy32}, 6'b111000);
      a8  = 8'(ra8);   b8  = 8'(rb8);   iv8  = 1'b1;
      a16 = 16'(ra16); b16 = 16'(rb16); iv16 = 1'b1;
      a32 = 32'(ra32); b32 = 32'(rb32); iv32 = 1'b1;
      tick();
      iv8 = 1'b0; iv16 = 1'b0; iv32 = 1'b0;
      seen = 3'b000;
      rg8 = 0; rg16 = 0; rg32 = 0; rc8 = 0; rc16 = 0; rc32 = 0;
      for (int t = 0; t < 140; t++) begin
        if (ov8  && !seen[0]) begin seen[0] = 1'b1; rg8  = g8;  rc8  = cyc8;  end
        if (ov16 && !seen[1]) begin seen[1] = 1'b1; rg16 = g16; rc16 = cyc16; end
        if (ov32 && !seen[2]) begin seen[2] = 1'b1; rg32 = g32; rc32 = cyc32; end
        if (seen == 3'b111) break;
        tick();
      end
      check("rnd_all_completed", seen, 3'b111);
      check("rnd_gcd8",  rg8,  ref_gcd(ra8,  rb8));
      check("rnd_gcd16", rg16, ref_gcd(ra16, rb16));
      check("rnd_gcd32", rg32, ref_gcd(ra32, rb32));
      check_le("rnd_cycles8",  rc8,  32);
      check_le("rnd_cycles16", rc16, 64);
      check_le("rnd_cycles32", rc32, 128);
      tick();
      if (seen != 3'b111) begin
        clear = 1'b1;
        tick();
        clear = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_gcd_engine
